uart_tx_fifo: RTL

Parametrised, register-mapped UART transmitter with a transmit FIFO, a programmable baud divisor, and a programmable frame format (data bits, parity, stop bits, break). It sits on the same 3-bit-address, 8-bit register bus as the other lab peripherals. It drives a single serial line, `txout`. It succeeds the fixed-period, single-byte transmitter and lets software queue bytes without polling each frame.

---
 rtl/uart_tx_fifo_if.sv | 18 +
 rtl/uart_tx_fifo.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - register bus bundle for the FIFO-backed UART transmitter
//
// Groups the 3-bit-address, 8-bit register bus.
//   wren  : register write strobe, one cycle per access
//   rden  : register read strobe, one cycle per access
//   addr  : register address
//   din   : write data
//   dout  : registered read data (driven by the peripheral)
interface uart_tx_fifo_if;
    logic       wren;
    logic       rden;
    logic [2:0] addr;
    logic [7:0] din;
    logic [7:0] dout;

    modport master (output wren, rden, addr, din, input dout);
    modport slave  (input wren, rden, addr, din, output dout);
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - register-mapped UART transmitter with TX FIFO and programmable frame
//
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : register bus (slave side): wren, rden, addr, din, dout
//   txout : serial line, idles high
// Registers: 0 TXDATA, 1 STATUS (W1C bits 3/4), 2 CTRL, 3 DIVLO, 4 DIVHI, 5 LEVEL.
module uart_tx_fifo #(
    parameter int          DATA_BITS   = 8,
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [15:0] DEFAULT_DIV = 16'h001A
) (
    input  logic           clk,
    input  logic           reset,
    uart_tx_fifo_if.slave  bus,
    output logic           txout
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2} state_t;

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wptr, r_rptr;
    logic [AW:0]          r_level;
    logic [4:0]           r_ctrl;
    logic [15:0]          r_div;
    logic                 r_ovf, r_done;
    logic [7:0]           r_dout;

    state_t               r_state;
    logic [15:0]          r_cnt;
    logic [15:0]          r_div_l;
    logic [DATA_BITS-1:0] r_shift;
    logic [2:0]           r_bitidx;
    logic                 r_par_en, r_par_bit, r_two_stop;
    logic                 r_line;

    logic                 w_empty, w_full, w_bit_end, w_frame_end;
    logic                 w_pop, w_push, w_wr_data;
    logic [DATA_BITS-1:0] w_head;

    assign w_empty     = (r_level == '0);
    assign w_full      = (r_level == (AW+1)'(FIFO_DEPTH));
    assign w_bit_end   = (r_cnt == r_div_l);
    assign w_frame_end = w_bit_end &&
                         ((r_state == S_STOP1 && !r_two_stop) || r_state == S_STOP2);
    // A pop happens only when the line is free: idle, or on the final stop-bit edge.
    assign w_pop       = !w_empty && r_ctrl[0] && (r_state == S_IDLE || w_frame_end);
    assign w_wr_data   = bus.wren && (bus.addr == 3'd0);
    // A pop on the same edge frees a slot, so a write to a full FIFO still lands.
    assign w_push      = w_wr_data && (!w_full || w_pop);
    assign w_head      = r_mem[r_rptr];

    // Break overrides the line combinationally from registered state.
    assign txout    = r_ctrl[4] ? 1'b0 : r_line;
    assign bus.dout = r_dout;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= bus.din[DATA_BITS-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Register file and read path.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ctrl <= 5'h01;
            r_div  <= DEFAULT_DIV;
            r_ovf  <= 1'b0;
            r_done <= 1'b0;
            r_dout <= 8'h00;
        end else begin
            if (bus.wren) begin
                case (bus.addr)
                    3'd2:    r_ctrl      <= bus.din[4:0];
                    3'd3:    r_div[7:0]  <= bus.din;
                    3'd4:    r_div[15:8] <= bus.din;
                    default: ;
                endcase
            end
            // Set events take priority over W1C clears on the same edge.
            if (w_wr_data && w_full && !w_pop)
                r_ovf <= 1'b1;
            else if (bus.wren && bus.addr == 3'd1 && bus.din[3])
                r_ovf <= 1'b0;
            if (w_frame_end)
                r_done <= 1'b1;
            else if (bus.wren && bus.addr == 3'd1 && bus.din[4])
                r_done <= 1'b0;
            if (bus.rden) begin
                case (bus.addr)
                    3'd1:    r_dout <= {3'b000, r_done, r_ovf, (r_state != S_IDLE), w_full, w_empty};
                    3'd2:    r_dout <= {3'b000, r_ctrl};
                    3'd3:    r_dout <= r_div[7:0];
                    3'd4:    r_dout <= r_div[15:8];
                    3'd5:    r_dout <= 8'(r_level);
                    default: r_dout <= 8'h00;
                endcase
            end
        end
    end

    // Transmit sequencer; r_cnt counts clocks within the current bit (0..DIV).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_div_l    <= '0;
            r_shift    <= '0;
            r_bitidx   <= '0;
            r_par_en   <= 1'b0;
            r_par_bit  <= 1'b0;
            r_two_stop <= 1'b0;
            r_line     <= 1'b1;
        end else if (w_pop) begin
            // Frame settings are latched here so mid-frame writes only affect the next frame.
            r_state    <= S_START;
            r_cnt      <= '0;
            r_div_l    <= r_div;
            r_shift    <= w_head;
            r_bitidx   <= '0;
            r_par_en   <= r_ctrl[1];
            r_par_bit  <= (^w_head) ^ r_ctrl[2];
            r_two_stop <= r_ctrl[3];
            r_line     <= 1'b0;
        end else if (r_state != S_IDLE) begin
            if (!w_bit_end) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
                case (r_state)
                    S_START: begin
                        r_state <= S_DATA;
                        r_line  <= r_shift[0];
                    end
                    S_DATA: begin
                        if (r_bitidx == 3'(DATA_BITS - 1)) begin
                            r_state <= r_par_en ? S_PARITY : S_STOP1;
                            r_line  <= r_par_en ? r_par_bit : 1'b1;
                        end else begin
                            r_shift  <= r_shift >> 1;
                            r_line   <= r_shift[1];
                            r_bitidx <= r_bitidx + 1'b1;
                        end
                    end
                    S_PARITY: begin
                        r_state <= S_STOP1;
                        r_line  <= 1'b1;
                    end
                    S_STOP1: begin
                        r_state <= r_two_stop ? S_STOP2 : S_IDLE;
                        r_line  <= 1'b1;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_line  <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule
